// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA timing generator: lock-gated start-up, fixed-latency pixel fetch,
// and sync/blank delayed to line up with the returned pixel data.
module vga_timing_gen #(
    parameter int H_ACTIVE      = 640,
    parameter int H_FP          = 16,
    parameter int H_SYNC        = 96,
    parameter int H_BP          = 48,
    parameter int V_ACTIVE      = 480,
    parameter int V_FP          = 10,
    parameter int V_SYNC        = 2,
    parameter int V_BP          = 33,
    parameter int SYNC_POL      = 0,
    parameter int FETCH_LEAD    = 2,
    parameter int SETTLE_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pll_locked,
    output logic        pix_req,
    output logic [9:0]  pix_x,
    output logic [8:0]  pix_y,
    input  logic [23:0] pix_data,
    output logic [7:0]  vga_r,
    output logic [7:0]  vga_g,
    output logic [7:0]  vga_b,
    output logic        hsync,
    output logic        vsync,
    output logic        blank_n,
    output logic        sync_n,
    output logic        frame_start,
    output logic [15:0] frame_count,
    output logic        running
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;
    localparam int SW       = $clog2(SETTLE_CYCLES + 1);
    localparam logic SYNC_ACT = (SYNC_POL != 0);

    typedef enum logic [1:0] {WAIT_LOCK, SETTLE, RUN} state_t;

    state_t          state;
    logic            lock_meta;
    logic            lock_s;
    logic [SW-1:0]   settle_cnt;
    logic [9:0]      h;
    logic [9:0]      v;
    logic            hs_req;
    logic            vs_req;
    logic [FETCH_LEAD-1:0] vis_pipe;
    logic [FETCH_LEAD-1:0] hs_pipe;
    logic [FETCH_LEAD-1:0] vs_pipe;
    logic            visible;

    assign sync_n  = 1'b0;
    assign visible = (h < 10'(H_ACTIVE)) && (v < 10'(V_ACTIVE));

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= WAIT_LOCK;
            lock_meta   <= 1'b0;
            lock_s      <= 1'b0;
            settle_cnt  <= '0;
            h           <= '0;
            v           <= '0;
            pix_req     <= 1'b0;
            pix_x       <= '0;
            pix_y       <= '0;
            hs_req      <= 1'b0;
            vs_req      <= 1'b0;
            vis_pipe    <= '0;
            hs_pipe     <= '0;
            vs_pipe     <= '0;
            vga_r       <= '0;
            vga_g       <= '0;
            vga_b       <= '0;
            hsync       <= ~SYNC_ACT;
            vsync       <= ~SYNC_ACT;
            blank_n     <= 1'b0;
            frame_start <= 1'b0;
            frame_count <= '0;
            running     <= 1'b0;
        end else begin
            lock_meta   <= pll_locked;
            lock_s      <= lock_meta;
            pix_req     <= 1'b0;
            hs_req      <= 1'b0;
            vs_req      <= 1'b0;
            frame_start <= 1'b0;

            // Sync/blank follow the request by FETCH_LEAD+1 cycles, matching pix_data.
            vis_pipe[0] <= pix_req;
            hs_pipe[0]  <= hs_req;
            vs_pipe[0]  <= vs_req;
            for (int i = 1; i < FETCH_LEAD; i++) begin
                vis_pipe[i] <= vis_pipe[i-1];
                hs_pipe[i]  <= hs_pipe[i-1];
                vs_pipe[i]  <= vs_pipe[i-1];
            end
            blank_n <= vis_pipe[FETCH_LEAD-1];
            hsync   <= hs_pipe[FETCH_LEAD-1] ? SYNC_ACT : ~SYNC_ACT;
            vsync   <= vs_pipe[FETCH_LEAD-1] ? SYNC_ACT : ~SYNC_ACT;
            if (vis_pipe[FETCH_LEAD-1]) begin
                vga_r <= pix_data[23:16];
                vga_g <= pix_data[15:8];
                vga_b <= pix_data[7:0];
            end else begin
                vga_r <= '0;
                vga_g <= '0;
                vga_b <= '0;
            end

            case (state)
                WAIT_LOCK: begin
                    h          <= '0;
                    v          <= '0;
                    settle_cnt <= '0;
                    running    <= 1'b0;
                    if (lock_s) state <= SETTLE;
                end
                SETTLE: begin
                    if (!lock_s) begin
                        state      <= WAIT_LOCK;
                        settle_cnt <= '0;
                    end else if (settle_cnt == SW'(SETTLE_CYCLES - 1)) begin
                        state   <= RUN;
                        running <= 1'b1;
                        h       <= '0;
                        v       <= '0;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                RUN: begin
                    if (!lock_s) begin
                        // Lock lost: drop in-flight fetches and blank the outputs now.
                        state    <= WAIT_LOCK;
                        running  <= 1'b0;
                        h        <= '0;
                        v        <= '0;
                        vis_pipe <= '0;
                        hs_pipe  <= '0;
                        vs_pipe  <= '0;
                        blank_n  <= 1'b0;
                        hsync    <= ~SYNC_ACT;
                        vsync    <= ~SYNC_ACT;
                        vga_r    <= '0;
                        vga_g    <= '0;
                        vga_b    <= '0;
                    end else begin
                        pix_req <= visible;
                        if (visible) begin
                            pix_x <= h;
                            pix_y <= v[8:0];
                        end
                        hs_req <= (h >= 10'(HS_START)) && (h < 10'(HS_END));
                        vs_req <= (v >= 10'(VS_START)) && (v < 10'(VS_END));
                        if (h == '0 && v == '0) begin
                            frame_start <= 1'b1;
                            frame_count <= frame_count + 1'b1;
                        end
                        if (h == 10'(H_TOTAL - 1)) begin
                            h <= '0;
                            v <= (v == 10'(V_TOTAL - 1)) ? '0 : v + 1'b1;
                        end else begin
                            h <= h + 1'b1;
                        end
                    end
                end
                default: state <= WAIT_LOCK;
            endcase
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a shrunken raster (32x13 total, 16x6 visible),
// active-high syncs, with a fixed-latency pixel memory model and a pixel scoreboard.
module tb_vga_timing_gen;

    localparam int HA = 16, HF = 4, HS = 6, HB = 6;
    localparam int VA = 6,  VF = 2, VS = 2, VB = 3;
    localparam int SP = 1, L = 2, S = 20;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;
    localparam logic ACT = 1'b1;
    localparam logic INACT = 1'b0;

    logic        clk, rst, pll_locked;
    logic        pix_req;
    logic [9:0]  pix_x;
    logic [8:0]  pix_y;
    logic [23:0] pix_data;
    logic [7:0]  vga_r, vga_g, vga_b;
    logic        hsync, vsync, blank_n, sync_n, frame_start, running;
    logic [15:0] frame_count;

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SYNC_POL(SP), .FETCH_LEAD(L), .SETTLE_CYCLES(S)
    ) dut (
        .clk(clk), .rst(rst), .pll_locked(pll_locked),
        .pix_req(pix_req), .pix_x(pix_x), .pix_y(pix_y), .pix_data(pix_data),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .hsync(hsync), .vsync(vsync), .blank_n(blank_n), .sync_n(sync_n),
        .frame_start(frame_start), .frame_count(frame_count), .running(running)
    );

    int checks = 0;
    int passes = 0;
    int cyc = 0;
    logic [23:0] exp_q[$];
    int          due_q[$];
    int          ex = 0, ey = 0;
    logic        hv[0:L];
    logic [9:0]  hx[0:L];
    logic [8:0]  hy[0:L];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model plus scoreboard, evaluated mid-cycle.
    always @(negedge clk) begin
        logic [23:0] exp_d;
        int          exp_t;
        for (int k = L; k > 0; k--) begin
            hv[k] = hv[k-1];
            hx[k] = hx[k-1];
            hy[k] = hy[k-1];
        end
        hv[0] = pix_req;
        hx[0] = pix_x;
        hy[0] = pix_y;
        if (hv[L] === 1'b1) pix_data = {hx[L][7:0], hy[L][7:0], 8'hA5};
        else pix_data = 24'($urandom);

        checks++;
        if (blank_n === 1'b1) begin
            if (exp_q.size() == 0) begin
                $display("FAIL sb_pixel: rgb=%h shown with no pending request", {vga_r, vga_g, vga_b});
            end else begin
                exp_d = exp_q.pop_front();
                exp_t = due_q.pop_front();
                if ({vga_r, vga_g, vga_b} !== exp_d || cyc != exp_t)
                    $display("FAIL sb_pixel: rgb=%h at cycle %0d, expected %h at cycle %0d",
                             {vga_r, vga_g, vga_b}, cyc, exp_d, exp_t);
                else passes++;
            end
        end else begin
            if ({vga_r, vga_g, vga_b} !== 24'h0)
                $display("FAIL blank_rgb: rgb=%h during blanking, expected 000000", {vga_r, vga_g, vga_b});
            else passes++;
        end

        if (pix_req === 1'b1) begin
            checks++;
            if (pix_x !== 10'(ex) || pix_y !== 9'(ey))
                $display("FAIL raster: request (%0d,%0d), expected (%0d,%0d)", pix_x, pix_y, ex, ey);
            else passes++;
            exp_q.push_back({8'(ex), 8'(ey), 8'hA5});
            due_q.push_back(cyc + L + 1);
            ex++;
            if (ex == HA) begin
                ex = 0;
                ey++;
                if (ey == VA) ey = 0;
            end
        end

        if (frame_start === 1'b1) begin
            checks++;
            if (!(pix_req === 1'b1 && pix_x == 10'd0 && pix_y == 9'd0))
                $display("FAIL frame_start_pos: pulse with req=%b at (%0d,%0d), expected req at (0,0)",
                         pix_req, pix_x, pix_y);
            else passes++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        exp_q.delete();
        due_q.delete();
        ex = 0;
        ey = 0;
    endtask

    task automatic test_reset();
        int  n;
        bit  got, saw_req;
        rst = 1'b1;
        pll_locked = 1'b1;
        repeat (3) step();
        checks++; if (pix_req !== 1'b0) $display("FAIL rst_pix_req: %b, expected 0", pix_req); else passes++;
        checks++; if (pix_x !== 10'd0) $display("FAIL rst_pix_x: %0d, expected 0", pix_x); else passes++;
        checks++; if (pix_y !== 9'd0) $display("FAIL rst_pix_y: %0d, expected 0", pix_y); else passes++;
        checks++; if (frame_start !== 1'b0) $display("FAIL rst_frame_start: %b, expected 0", frame_start); else passes++;
        checks++; if (frame_count !== 16'd0) $display("FAIL rst_frame_count: %0d, expected 0", frame_count); else passes++;
        checks++; if (running !== 1'b0) $display("FAIL rst_running: %b, expected 0", running); else passes++;
        checks++; if (blank_n !== 1'b0) $display("FAIL rst_blank_n: %b, expected 0", blank_n); else passes++;
        checks++; if (hsync !== INACT) $display("FAIL rst_hsync: %b, expected %b", hsync, INACT); else passes++;
        checks++; if (vsync !== INACT) $display("FAIL rst_vsync: %b, expected %b", vsync, INACT); else passes++;
        checks++; if (sync_n !== 1'b0) $display("FAIL rst_sync_n: %b, expected 0", sync_n); else passes++;
        checks++;
        if ({vga_r, vga_g, vga_b} !== 24'h0) $display("FAIL rst_rgb: %h, expected 000000", {vga_r, vga_g, vga_b});
        else passes++;
        clear_model();
        rst = 1'b0;
        n = 0; got = 0; saw_req = 0;
        while (n < S + 50 && !got) begin
            step();
            n++;
            if (running === 1'b1) got = 1;
            else if (pix_req === 1'b1) saw_req = 1;
        end
        checks++;
        if (!got || n != S + 3) $display("FAIL startup_latency: running after %0d cycles (seen=%0d), expected %0d", n, got, S + 3);
        else passes++;
        checks++;
        if (saw_req) $display("FAIL startup_req: pix_req=1 before running, expected 0"); else passes++;
    endtask

    task automatic test_frame_timing();
        int  n, hs_last, hs_rises, hs_w, vs_last, vs_rises, vs_w, fs_last, fs_n, req_cnt, bl_cnt;
        bit  hs_prev, vs_prev, hs_trk, vs_trk, hs_now, vs_now;
        n = 0;
        while (n < FRAME + 10 && frame_start !== 1'b1) begin step(); n++; end
        checks++;
        if (frame_start !== 1'b1) begin
            $display("FAIL wait_frame_start: %b, expected 1 within %0d cycles", frame_start, FRAME + 10);
            return;
        end else passes++;
        checks++;
        if (frame_count !== 16'd1) $display("FAIL first_frame_count: %0d, expected 1", frame_count); else passes++;
        hs_prev = (hsync === ACT); vs_prev = (vsync === ACT);
        hs_trk = 0; vs_trk = 0; hs_rises = 0; vs_rises = 0; hs_w = 0; vs_w = 0;
        hs_last = 0; vs_last = 0; fs_last = 0; fs_n = 0; req_cnt = 1; bl_cnt = 0;
        for (int t = 1; t <= 3 * FRAME; t++) begin
            step();
            hs_now = (hsync === ACT);
            vs_now = (vsync === ACT);
            if (hs_now && !hs_prev) begin
                if (hs_rises > 0) begin
                    checks++;
                    if (t - hs_last != HT) $display("FAIL hsync_period: %0d, expected %0d", t - hs_last, HT);
                    else passes++;
                    checks++;
                    if (bl_cnt != HA && bl_cnt != 0) $display("FAIL line_pixels: %0d, expected %0d or 0", bl_cnt, HA);
                    else passes++;
                end
                hs_last = t; hs_rises++; hs_w = 0; hs_trk = 1; bl_cnt = 0;
            end
            if (hs_now) hs_w++;
            if (!hs_now && hs_prev && hs_trk) begin
                checks++;
                if (hs_w != HS) $display("FAIL hsync_width: %0d, expected %0d", hs_w, HS); else passes++;
            end
            if (vs_now && !vs_prev) begin
                if (vs_rises > 0) begin
                    checks++;
                    if (t - vs_last != FRAME) $display("FAIL vsync_period: %0d, expected %0d", t - vs_last, FRAME);
                    else passes++;
                end
                vs_last = t; vs_rises++; vs_w = 0; vs_trk = 1;
            end
            if (vs_now) vs_w++;
            if (!vs_now && vs_prev && vs_trk) begin
                checks++;
                if (vs_w != VS * HT) $display("FAIL vsync_width: %0d, expected %0d", vs_w, VS * HT); else passes++;
            end
            if (blank_n === 1'b1) bl_cnt++;
            if (frame_start === 1'b1) begin
                fs_n++;
                checks++;
                if (t - fs_last != FRAME) $display("FAIL frame_period: %0d, expected %0d", t - fs_last, FRAME);
                else passes++;
                fs_last = t;
                if (fs_n == 1) begin
                    checks++;
                    if (req_cnt != HA * VA) $display("FAIL frame_reqs: %0d, expected %0d", req_cnt, HA * VA);
                    else passes++;
                end
                if (fs_n == 2) begin
                    checks++;
                    if (frame_count !== 16'd3) $display("FAIL frame_count3: %0d, expected 3", frame_count);
                    else passes++;
                end
            end
            if (pix_req === 1'b1 && fs_n == 0) req_cnt++;
            hs_prev = hs_now;
            vs_prev = vs_now;
        end
        checks++;
        if (fs_n != 3) $display("FAIL frame_starts: %0d seen, expected 3", fs_n); else passes++;
    endtask

    task automatic test_data_alignment();
        int n;
        n = 0;
        while (n < FRAME + 10 && frame_start !== 1'b1) begin step(); n++; end
        n = 0;
        while (n < 20 && blank_n !== 1'b1) begin step(); n++; end
        checks++;
        if (n != L + 1) $display("FAIL first_pixel_latency: %0d, expected %0d", n, L + 1); else passes++;
        checks++;
        if ({vga_r, vga_g, vga_b} !== 24'h0000A5)
            $display("FAIL first_pixel_rgb: %h, expected 0000a5", {vga_r, vga_g, vga_b});
        else passes++;
        n = 0;
        while (n < FRAME + 10 && !(pix_req === 1'b1 && pix_x == 10'(HA - 1) && pix_y == 9'(VA - 1))) begin
            step(); n++;
        end
        repeat (L + 1) step();
        checks++;
        if (blank_n !== 1'b1 || {vga_r, vga_g, vga_b} !== {8'(HA - 1), 8'(VA - 1), 8'hA5})
            $display("FAIL last_pixel: blank_n=%b rgb=%h, expected 1 %h", blank_n, {vga_r, vga_g, vga_b},
                     {8'(HA - 1), 8'(VA - 1), 8'hA5});
        else passes++;
        step();
        checks++;
        if (blank_n !== 1'b0 || {vga_r, vga_g, vga_b} !== 24'h0)
            $display("FAIL after_last_pixel: blank_n=%b rgb=%h, expected 0 000000", blank_n, {vga_r, vga_g, vga_b});
        else passes++;
    endtask

    task automatic test_lock_loss();
        int n;
        n = 0;
        while (n < 2 * FRAME && !(pix_req === 1'b1 && pix_x == 10'd8 && pix_y == 9'd3)) begin step(); n++; end
        pll_locked = 1'b0;
        repeat (2) step();
        checks++;
        if (running !== 1'b1) $display("FAIL lock_sync_delay: running=%b, expected 1", running); else passes++;
        step();
        checks++; if (running !== 1'b0) $display("FAIL loss_running: %b, expected 0", running); else passes++;
        checks++; if (blank_n !== 1'b0) $display("FAIL loss_blank_n: %b, expected 0", blank_n); else passes++;
        checks++;
        if ({vga_r, vga_g, vga_b} !== 24'h0) $display("FAIL loss_rgb: %h, expected 000000", {vga_r, vga_g, vga_b});
        else passes++;
        checks++;
        if (hsync !== INACT || vsync !== INACT)
            $display("FAIL loss_syncs: hsync=%b vsync=%b, expected %b %b", hsync, vsync, INACT, INACT);
        else passes++;
        checks++; if (pix_req !== 1'b0) $display("FAIL loss_pix_req: %b, expected 0", pix_req); else passes++;
        clear_model();
        pll_locked = 1'b1;
        n = 0;
        while (n < S + 50 && running !== 1'b1) begin step(); n++; end
        checks++;
        if (n != S + 3) $display("FAIL relock_latency: %0d, expected %0d", n, S + 3); else passes++;
        step();
        checks++;
        if (frame_start !== 1'b1 || pix_req !== 1'b1 || pix_x !== 10'd0 || pix_y !== 9'd0)
            $display("FAIL restart_origin: fs=%b req=%b (%0d,%0d), expected 1 1 (0,0)",
                     frame_start, pix_req, pix_x, pix_y);
        else passes++;
    endtask

    task automatic test_lock_glitch();
        int n;
        rst = 1'b1;
        repeat (2) step();
        clear_model();
        rst = 1'b0;
        repeat (13) step();
        pll_locked = 1'b0;
        step();
        pll_locked = 1'b1;
        n = 0;
        while (n < S + 50 && running !== 1'b1) begin step(); n++; end
        checks++;
        if (n != S + 3) $display("FAIL glitch_latency: %0d, expected %0d", n, S + 3); else passes++;
    endtask

    task automatic test_reset_mid_line();
        int n;
        n = 0;
        while (n < 2 * FRAME && !(pix_req === 1'b1 && pix_x == 10'(HA - 1))) begin step(); n++; end
        repeat (10) step();
        checks++;
        if (hsync !== ACT) $display("FAIL pre_reset_hsync: %b, expected %b", hsync, ACT); else passes++;
        rst = 1'b1;
        step();
        checks++; if (hsync !== INACT) $display("FAIL mid_rst_hsync: %b, expected %b", hsync, INACT); else passes++;
        checks++; if (vsync !== INACT) $display("FAIL mid_rst_vsync: %b, expected %b", vsync, INACT); else passes++;
        checks++; if (frame_count !== 16'd0) $display("FAIL mid_rst_frame_count: %0d, expected 0", frame_count); else passes++;
        checks++; if (running !== 1'b0) $display("FAIL mid_rst_running: %b, expected 0", running); else passes++;
        checks++;
        if (pix_req !== 1'b0 || pix_x !== 10'd0 || pix_y !== 9'd0)
            $display("FAIL mid_rst_req: req=%b (%0d,%0d), expected 0 (0,0)", pix_req, pix_x, pix_y);
        else passes++;
        checks++; if (blank_n !== 1'b0) $display("FAIL mid_rst_blank_n: %b, expected 0", blank_n); else passes++;
        clear_model();
        rst = 1'b0;
        repeat (4) step();
    endtask

    initial begin
        rst = 1'b1;
        pll_locked = 1'b0;
        pix_data = '0;
        for (int k = 0; k <= L; k++) begin
            hv[k] = 1'b0;
            hx[k] = '0;
            hy[k] = '0;
        end
        test_reset();
        test_frame_timing();
        test_data_alignment();
        test_lock_loss();
        test_lock_glitch();
        test_reset_mid_line();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
